uart_tx_fifo_drain: RTL and testbench

- Serial transmit stage directly downstream of the trace output FIFO (Width=8 registered FIFO).
- Pops one word at a time from the FIFO's first-word-fall-through read port and shifts it out as an asynchronous UART frame to the host.
- Back-to-back frames are sent with no idle gap while the FIFO holds data.
- Only consumer of the FIFO read side; guarantees no underflow, which the FIFO does not check.

---
 rtl/uart_tx_fifo_drain_pkg.sv | 30 +++
 rtl/uart_tx_fifo_drain_baud_ctr.sv | 30 +++
 rtl/uart_tx_fifo_drain.sv | 135 +++++++++++++
 tb/tb_uart_tx_fifo_drain.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_fifo_drain_pkg.sv
// Shared state encodings and elaboration helpers for the FIFO-draining UART transmitter.
package uart_tx_fifo_drain_pkg;

    localparam int unsigned STATE_W = 3;

    localparam logic [STATE_W-1:0] ST_IDLE   = 3'd0;
    localparam logic [STATE_W-1:0] ST_START  = 3'd1;
    localparam logic [STATE_W-1:0] ST_DATA   = 3'd2;
    localparam logic [STATE_W-1:0] ST_PARITY = 3'd3;
    localparam logic [STATE_W-1:0] ST_STOP   = 3'd4;

    // Ceiling log2, usable in localparam expressions.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        while ((64'd1 << result) < 64'(value)) begin
            result = result + 1;
        end
        return result;
    endfunction

    // Clock cycles occupied by one complete frame.
    function automatic int unsigned frame_len(input int unsigned width,
                                              input int unsigned clk_div,
                                              input int unsigned stop_bits,
                                              input int unsigned parity_en);
        return (1 + width + parity_en + stop_bits) * clk_div;
    endfunction

endpackage

// File: rtl/uart_tx_fifo_drain_baud_ctr.sv
// Bit-period counter: restart clears it, bit_end marks the last clk of each serial bit.
module uart_tx_fifo_drain_baud_ctr
    import uart_tx_fifo_drain_pkg::*;
#(
    parameter int unsigned ClkDiv = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic bit_end
);

    localparam int unsigned CNT_W = (clog2(ClkDiv) > 0) ? clog2(ClkDiv) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ClkDiv - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (restart || (cnt == CNT_LAST)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign bit_end = (cnt == CNT_LAST);

endmodule

// File: rtl/uart_tx_fifo_drain.sv
// UART transmitter draining a first-word-fall-through FIFO: one pop per frame,
// back-to-back frames with no idle gap while data is available.
module uart_tx_fifo_drain
    import uart_tx_fifo_drain_pkg::*;
#(
    parameter int unsigned Width     = 8,
    parameter int unsigned ClkDiv    = 16,
    parameter int unsigned StopBits  = 1,
    parameter int unsigned ParityEn  = 0,
    parameter int unsigned ParityOdd = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             fifo_empty,
    input  logic [Width-1:0] fifo_data,
    output logic             fifo_rd_en,
    output logic             tx,
    output logic             busy,
    output logic             done
);

    localparam int unsigned BIT_W = (clog2(Width) > 0) ? clog2(Width) : 1;
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(Width - 1);
    localparam logic STOP_LAST = 1'(StopBits - 1);

    logic [STATE_W-1:0] state, state_next;
    logic [Width-1:0]   shreg, shreg_next;
    logic [BIT_W-1:0]   bit_cnt, bit_cnt_next;
    logic               stop_cnt, stop_cnt_next;
    logic               parity, parity_next;
    logic               tx_next, busy_next;
    logic               armed;
    logic               bit_end;
    logic               restart_c, last_stop_c, pop_c;

    uart_tx_fifo_drain_baud_ctr #(
        .ClkDiv (ClkDiv)
    ) u_baud_ctr (
        .clk     (clk),
        .rst_n   (rst_n),
        .restart (restart_c),
        .bit_end (bit_end)
    );

    // State, datapath and registered line outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            shreg    <= '0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            parity   <= 1'b0;
            armed    <= 1'b0;
            tx       <= 1'b1;
            busy     <= 1'b0;
        end else begin
            state    <= state_next;
            shreg    <= shreg_next;
            bit_cnt  <= bit_cnt_next;
            stop_cnt <= stop_cnt_next;
            parity   <= parity_next;
            armed    <= 1'b1;
            tx       <= tx_next;
            busy     <= busy_next;
        end
    end

    // Next-state, pop decision and next line value.
    always_comb begin
        state_next    = state;
        shreg_next    = shreg;
        bit_cnt_next  = bit_cnt;
        stop_cnt_next = stop_cnt;
        parity_next   = parity;
        tx_next       = 1'b1;

        last_stop_c = (state == ST_STOP) && bit_end && (stop_cnt == STOP_LAST);
        pop_c       = ((state == ST_IDLE) || last_stop_c) && en && !fifo_empty && armed;

        if (pop_c) begin
            state_next    = ST_START;
            shreg_next    = fifo_data;
            parity_next   = (^fifo_data) ^ 1'(ParityOdd);
            bit_cnt_next  = '0;
            stop_cnt_next = 1'b0;
        end else begin
            case (state)
                ST_START: begin
                    if (bit_end) begin
                        state_next = ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        shreg_next = shreg >> 1;
                        if (bit_cnt == BIT_LAST) begin
                            state_next = (ParityEn != 0) ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_cnt_next = bit_cnt + BIT_W'(1);
                        end
                    end
                end
                ST_PARITY: begin
                    if (bit_end) begin
                        state_next = ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (last_stop_c) begin
                        state_next = ST_IDLE;
                    end else if (bit_end) begin
                        stop_cnt_next = 1'b1;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end

        case (state_next)
            ST_START:  tx_next = 1'b0;
            ST_DATA:   tx_next = shreg_next[0];
            ST_PARITY: tx_next = parity_next;
            default:   tx_next = 1'b1;
        endcase

        busy_next = (state_next != ST_IDLE);
        // IDLE holds the bit counter at zero so every new state starts a full bit period.
        restart_c = (state == ST_IDLE) || (state_next != state);
    end

    assign fifo_rd_en = pop_c;
    assign done       = last_stop_c;

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// Directed bench for uart_tx_fifo_drain: three parameterisations, FIFO model,
// and a frame scoreboard that rebuilds the expected tx waveform per popped word.
module tb_uart_tx_fifo_drain;

    localparam int CLK_DIV = 4;

    int pe_t [3] = '{0, 1, 1};
    int po_t [3] = '{0, 0, 1};
    int sb_t [3] = '{1, 1, 2};

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en [3];
    logic       fifo_empty [3];
    logic [7:0] fifo_data [3];
    logic       fifo_rd_en [3];
    logic       tx [3];
    logic       busy [3];
    logic       done [3];

    logic [7:0] mem [3][16];
    int wr [3] = '{0, 0, 0};
    int rd [3] = '{0, 0, 0};
    int pops [3] = '{0, 0, 0};

    logic [7:0] exp0 [$];
    logic [7:0] exp1 [$];
    logic [7:0] exp2 [$];

    int n_cmp = 0;
    int n_err = 0;

    bit          act [3] = '{0, 0, 0};
    int          k [3];
    logic [63:0] wave [3];
    int          bcnt [3];
    int          dcnt [3];
    int          dat [3];
    int          frames [3] = '{0, 0, 0};
    int          last_pop [3] = '{0, 0, 0};
    int          prev_pop [3] = '{0, 0, 0};
    int          cyc = 0;

    always #5 clk = ~clk;

    uart_tx_fifo_drain #(.Width(8), .ClkDiv(CLK_DIV), .StopBits(1), .ParityEn(0), .ParityOdd(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .en(en[0]), .fifo_empty(fifo_empty[0]), .fifo_data(fifo_data[0]),
        .fifo_rd_en(fifo_rd_en[0]), .tx(tx[0]), .busy(busy[0]), .done(done[0]));
    uart_tx_fifo_drain #(.Width(8), .ClkDiv(CLK_DIV), .StopBits(1), .ParityEn(1), .ParityOdd(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en[1]), .fifo_empty(fifo_empty[1]), .fifo_data(fifo_data[1]),
        .fifo_rd_en(fifo_rd_en[1]), .tx(tx[1]), .busy(busy[1]), .done(done[1]));
    uart_tx_fifo_drain #(.Width(8), .ClkDiv(CLK_DIV), .StopBits(2), .ParityEn(1), .ParityOdd(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .en(en[2]), .fifo_empty(fifo_empty[2]), .fifo_data(fifo_data[2]),
        .fifo_rd_en(fifo_rd_en[2]), .tx(tx[2]), .busy(busy[2]), .done(done[2]));

    assign fifo_empty[0] = (wr[0] == rd[0]);
    assign fifo_empty[1] = (wr[1] == rd[1]);
    assign fifo_empty[2] = (wr[2] == rd[2]);
    assign fifo_data[0]  = mem[0][4'(rd[0])];
    assign fifo_data[1]  = mem[1][4'(rd[1])];
    assign fifo_data[2]  = mem[2][4'(rd[2])];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic int flen(input int i);
        return (1 + 8 + pe_t[i] + sb_t[i]) * CLK_DIV;
    endfunction

    // Expected line, bit (c-1) = tx in frame cycle c.
    function automatic logic [63:0] exp_wave(input int i, input logic [7:0] v);
        logic [63:0] w;
        int pos;
        logic b;
        w = '0;
        pos = 0;
        for (int j = 0; j < 1 + 8 + pe_t[i] + sb_t[i]; j++) begin
            if (j == 0)                        b = 1'b0;
            else if (j <= 8)                   b = v[j-1];
            else if (pe_t[i] != 0 && j == 9)   b = (^v) ^ (po_t[i] != 0);
            else                               b = 1'b1;
            for (int c = 0; c < CLK_DIV; c++) begin
                w[6'(pos)] = b;
                pos++;
            end
        end
        return w;
    endfunction

    task automatic exp_push(input int i, input logic [7:0] v);
        case (i)
            0:       exp0.push_back(v);
            1:       exp1.push_back(v);
            default: exp2.push_back(v);
        endcase
    endtask

    function automatic bit exp_pop(input int i, output logic [7:0] v);
        v = 8'h00;
        case (i)
            0: begin if (exp0.size() == 0) return 1'b0; v = exp0.pop_front(); end
            1: begin if (exp1.size() == 0) return 1'b0; v = exp1.pop_front(); end
            default: begin if (exp2.size() == 0) return 1'b0; v = exp2.pop_front(); end
        endcase
        return 1'b1;
    endfunction

    task automatic push(input int i, input logic [7:0] v);
        mem[i][4'(wr[i])] = v;
        wr[i] = wr[i] + 1;
        exp_push(i, v);
    endtask

    task automatic finish_frame(input int i);
        logic [7:0] v;
        bit have;
        frames[i]++;
        have = exp_pop(i, v);
        chk($sformatf("d%0d_sb_entry", i), 64'(have), 64'd1);
        if (have) chk($sformatf("d%0d_frame_tx_%02h", i, v), wave[i], exp_wave(i, v));
        chk($sformatf("d%0d_frame_busy", i), 64'(bcnt[i]), 64'(flen(i)));
        chk($sformatf("d%0d_frame_done_at", i), 64'(dat[i]), 64'(flen(i)));
        chk($sformatf("d%0d_frame_done_cnt", i), 64'(dcnt[i]), 64'd1);
    endtask

    task automatic wait_frames(input int i, input int target, input int budget, input string tag);
        int b;
        b = budget;
        while (frames[i] < target && b > 0) begin
            @(negedge clk); #2;
            b--;
        end
        chk({tag, "_frame_wait"}, 64'(frames[i] >= target), 64'd1);
    endtask

    task automatic wait_pop(input int i, input int p, input string tag);
        int b;
        b = 100;
        while (pops[i] == p && b > 0) begin
            @(negedge clk); #2;
            b--;
        end
        chk({tag, "_pop_seen"}, 64'(pops[i] - p), 64'd1);
    endtask

    // FIFO read side: pops on each strobe, flags a read while empty.
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (fifo_rd_en[i] === 1'b1) begin
                chk($sformatf("d%0d_rd_when_empty", i), 64'(fifo_empty[i]), 64'd0);
                if (wr[i] != rd[i]) rd[i] <= rd[i] + 1;
                pops[i] <= pops[i] + 1;
            end
        end
    end

    // Frame monitor: captures tx/busy/done over each frame and scores it on its last cycle.
    always begin
        @(negedge clk); #2;
        cyc++;
        for (int i = 0; i < 3; i++) begin
            if (!rst_n) begin
                act[i] = 1'b0;
            end else begin
                if (act[i]) begin
                    k[i]++;
                    wave[i][6'(k[i] - 1)] = tx[i];
                    if (busy[i] === 1'b1) bcnt[i]++;
                    if (done[i] === 1'b1) begin
                        dcnt[i]++;
                        dat[i] = k[i];
                    end
                    if (k[i] == flen(i)) begin
                        act[i] = 1'b0;
                        finish_frame(i);
                    end
                end else begin
                    chk($sformatf("d%0d_idle_busy_done_tx", i), 64'({busy[i], done[i], tx[i]}), 64'b001);
                end
                if (fifo_rd_en[i] === 1'b1) begin
                    chk($sformatf("d%0d_pop_in_frame", i), 64'(act[i]), 64'd0);
                    prev_pop[i] = last_pop[i];
                    last_pop[i] = cyc;
                    act[i]  = 1'b1;
                    k[i]    = 0;
                    wave[i] = '0;
                    bcnt[i] = 0;
                    dcnt[i] = 0;
                    dat[i]  = 0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int p, p1, p2, f, f1, f2, bad;
        rst_n = 1'b0;
        en    = '{1'b0, 1'b0, 1'b0};

        // 1: reset state, then idle with an empty FIFO
        repeat (5) @(negedge clk);
        #2;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("d%0d_rst_tx", i), 64'(tx[i]), 64'd1);
            chk($sformatf("d%0d_rst_busy", i), 64'(busy[i]), 64'd0);
            chk($sformatf("d%0d_rst_done", i), 64'(done[i]), 64'd0);
            chk($sformatf("d%0d_rst_rd_en", i), 64'(fifo_rd_en[i]), 64'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        en[0] = 1'b1;
        bad = 0;
        repeat (20) begin
            @(negedge clk); #2;
            if (fifo_rd_en[0] !== 1'b0) bad++;
        end
        chk("t1_rd_en_cycles", 64'(bad), 64'd0);
        chk("t1_pops", 64'(pops[0]), 64'd0);

        // 2: single word 0xA5
        @(negedge clk);
        p = pops[0];
        f = frames[0];
        push(0, 8'hA5);
        wait_frames(0, f + 1, 100, "t2");
        chk("t2_pops", 64'(pops[0] - p), 64'd1);
        @(negedge clk); #2;
        chk("t2_after_busy", 64'(busy[0]), 64'd0);
        chk("t2_after_tx", 64'(tx[0]), 64'd1);

        // 3: back-to-back 0x00, 0xFF
        @(negedge clk);
        p = pops[0];
        f = frames[0];
        push(0, 8'h00);
        push(0, 8'hFF);
        wait_frames(0, f + 2, 200, "t3");
        chk("t3_pops", 64'(pops[0] - p), 64'd2);
        chk("t3_pop_gap", 64'(last_pop[0] - prev_pop[0]), 64'd40);

        // 4: parity even / odd with two stop bits
        @(negedge clk);
        p1 = pops[1];
        p2 = pops[2];
        f1 = frames[1];
        f2 = frames[2];
        en[1] = 1'b1;
        en[2] = 1'b1;
        push(1, 8'h07);
        push(1, 8'h03);
        push(2, 8'h07);
        wait_frames(1, f1 + 2, 200, "t4_even");
        wait_frames(2, f2 + 1, 200, "t4_odd");
        chk("t4_even_pops", 64'(pops[1] - p1), 64'd2);
        chk("t4_even_gap", 64'(last_pop[1] - prev_pop[1]), 64'd44);
        chk("t4_odd_pops", 64'(pops[2] - p2), 64'd1);

        // 5: asynchronous reset in frame cycle 15
        @(negedge clk);
        p = pops[0];
        push(0, 8'h11);
        push(0, 8'h22);
        wait_pop(0, p, "t5");
        repeat (14) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t5_async_tx", 64'(tx[0]), 64'd1);
        chk("t5_async_busy", 64'(busy[0]), 64'd0);
        begin
            logic [7:0] lost;
            void'(exp_pop(0, lost));
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        f = frames[0];
        wait_frames(0, f + 1, 200, "t5");
        chk("t5_pops", 64'(pops[0] - p), 64'd2);

        // 6: en low holds off pops; en dropped mid-frame finishes only that frame
        @(negedge clk);
        en[0] = 1'b0;
        p = pops[0];
        push(0, 8'h33);
        push(0, 8'h44);
        push(0, 8'h55);
        bad = 0;
        repeat (50) begin
            @(negedge clk); #2;
            if (fifo_rd_en[0] !== 1'b0) bad++;
        end
        chk("t6_rd_en_while_disabled", 64'(bad), 64'd0);
        chk("t6_pops_disabled", 64'(pops[0] - p), 64'd0);
        @(negedge clk);
        en[0] = 1'b1;
        f = frames[0];
        wait_pop(0, p, "t6");
        repeat (9) @(negedge clk);
        en[0] = 1'b0;
        wait_frames(0, f + 1, 200, "t6");
        repeat (50) @(negedge clk);
        #2;
        chk("t6_pops", 64'(pops[0] - p), 64'd1);
        chk("t6_end_busy", 64'(busy[0]), 64'd0);
        chk("t6_end_tx", 64'(tx[0]), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
